// File: rtl/sha256_round_if.sv
// rtl/sha256_round_if.sv - block/hash handshake between the feeder and the SHA-256 round core
interface sha256_round_if;
    logic         start;
    logic [511:0] block_in;
    logic [255:0] hash_in;
    logic         busy;
    logic         done;
    logic [255:0] hash_out;

    modport master (
        output start, block_in, hash_in,
        input  busy, done, hash_out
    );

    modport slave (
        input  start, block_in, hash_in,
        output busy, done, hash_out
    );
endinterface

// File: rtl/sha256_round_core.sv
// rtl/sha256_round_core.sv - SHA-256 compression, one round per clock, external registered K ROM
module sha256_round_core #(
    parameter int ROUNDS = 64,
    parameter int SEL_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    sha256_round_if.slave    bus,
    output logic [SEL_W-1:0] k_select,
    input  logic [31:0]      k_data
);
    localparam int RW = $clog2(ROUNDS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

    state_t         state;
    logic [RW-1:0]  round;
    logic [31:0]    a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
    logic [31:0]    w [16];
    logic [255:0]   h_cap;
    logic [255:0]   hash_q;
    logic           busy_q;
    logic           done_q;
    logic [31:0]    t1, t2, w_new;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    always_comb begin
        t1    = h_q + big_s1(e_q) + ((e_q & f_q) ^ (~e_q & g_q)) + k_data + w[0];
        t2    = big_s0(a_q) + ((a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q));
        w_new = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            round    <= '0;
            k_select <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hash_q   <= '0;
            h_cap    <= '0;
            a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
            e_q <= '0; f_q <= '0; g_q <= '0; h_q <= '0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < 16; i++) w[i] <= bus.block_in[511 - 32*i -: 32];
                        h_cap <= bus.hash_in;
                        {a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q} <= bus.hash_in;
                        round    <= '0;
                        k_select <= SEL_W'(1);
                        busy_q   <= 1'b1;
                        state    <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    h_q <= g_q;
                    g_q <= f_q;
                    f_q <= e_q;
                    e_q <= d_q + t1;
                    d_q <= c_q;
                    c_q <= b_q;
                    b_q <= a_q;
                    a_q <= t1 + t2;
                    for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                    w[15] <= w_new;
                    // ROM is one cycle behind its address, so select K[r+2] while consuming K[r]
                    if (round == RW'(ROUNDS - 1)) begin
                        k_select <= '0;
                        state    <= S_FINAL;
                    end else begin
                        round    <= round + 1'b1;
                        k_select <= SEL_W'(round) + SEL_W'(2);
                    end
                end
                S_FINAL: begin
                    hash_q <= {h_cap[255:224] + a_q, h_cap[223:192] + b_q,
                               h_cap[191:160] + c_q, h_cap[159:128] + d_q,
                               h_cap[127:96]  + e_q, h_cap[95:64]   + f_q,
                               h_cap[63:32]   + g_q, h_cap[31:0]    + h_q};
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hash_out = hash_q;
endmodule

// File: tb/tb_sha256_round_core.sv
// tb/tb_sha256_round_core.sv - self-checking bench for sha256_round_core
module tb_sha256_round_core;
    logic        clk;
    logic        rst_n;
    logic [5:0]  k_select;
    logic [31:0] k_data;

    sha256_round_if bus ();

    sha256_round_core #(.ROUNDS(64), .SEL_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .k_select (k_select),
        .k_data   (k_data)
    );

    logic [31:0] kc [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Registered K ROM: one cycle from address to data
    always @(posedge clk) k_data <= kc[k_select];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] IV      = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_H   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_H = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_H   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    // Straight FIPS 180-4 compression with a fully expanded 64-word schedule
    function automatic logic [255:0] ref_compress(input logic [255:0] hv, input logic [511:0] blk);
        logic [31:0] ws [64];
        logic [31:0] v  [8];
        logic [31:0] x1, x2, s0, s1;
        logic [255:0] r;
        for (int t = 0; t < 16; t++) ws[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(ws[t-15], 7) ^ rr(ws[t-15], 18) ^ (ws[t-15] >> 3);
            s1 = rr(ws[t-2], 17) ^ rr(ws[t-2], 19) ^ (ws[t-2] >> 10);
            ws[t] = s1 + ws[t-7] + s0 + ws[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            x1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kc[t] + ws[t];
            x2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + x1;
            v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hv[255 - 32*i -: 32] + v[i];
        return r;
    endfunction

    typedef struct {
        logic [511:0] blk;
        logic [255:0] hin;
        logic [255:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic launch(input logic [511:0] b, input logic [255:0] hv);
        bus.start    = 1'b1;
        bus.block_in = b;
        bus.hash_in  = hv;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", {255'd0, bus.busy}, 256'd1);
        chk("done_low_after_start", {255'd0, bus.done}, 256'd0);
    endtask

    task automatic wait_done(input bit trace, output logic [255:0] res, output int cnt);
        cnt = 0;
        if (trace) chk("ksel_round0", {250'd0, k_select}, 256'd1);
        while (bus.done !== 1'b1 && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (trace) chk($sformatf("ksel_cyc%0d", cnt), {250'd0, k_select},
                           (cnt <= 63) ? 256'((cnt + 1) % 64) : 256'd0);
        end
        res = bus.hash_out;
    endtask

    logic [511:0] abc_blk, empty_blk, two_b1, two_b2, rblk;
    logic [255:0] rh, res, res2;
    int cnt, pulses;

    initial begin
        abc_blk   = {32'h61626380, 448'h0, 32'h00000018};
        empty_blk = {32'h80000000, 480'h0};
        two_b1    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        two_b2    = {480'h0, 32'h000001c0};

        tbl.push_back('{abc_blk, IV, ABC_H});
        tbl.push_back('{empty_blk, IV, EMPTY_H});
        for (int n = 0; n < 6; n++) begin
            for (int j = 0; j < 16; j++) rblk[32*j +: 32] = $urandom;
            for (int j = 0; j < 8; j++) rh[32*j +: 32] = $urandom;
            tbl.push_back('{rblk, rh, ref_compress(rh, rblk)});
        end

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.block_in = '0;
        bus.hash_in  = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {255'd0, bus.busy}, 256'd0);
        chk("reset_done", {255'd0, bus.done}, 256'd0);
        chk("reset_hash", bus.hash_out, 256'd0);
        chk("reset_ksel", {250'd0, k_select}, 256'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table: known vectors plus randomized blocks against the reference model
        foreach (tbl[i]) begin
            chk($sformatf("idle_ksel_%0d", i), {250'd0, k_select}, 256'd0);
            launch(tbl[i].blk, tbl[i].hin);
            wait_done(i == 0, res, cnt);
            chk($sformatf("latency_%0d", i), 256'(cnt), 256'd65);
            chk($sformatf("hash_%0d", i), res, tbl[i].exp);
            repeat (3) begin
                @(negedge clk);
                chk($sformatf("done_single_%0d", i), {255'd0, bus.done}, 256'd0);
            end
            chk($sformatf("hash_hold_%0d", i), bus.hash_out, tbl[i].exp);
        end

        // Two-block message, second block started on the done cycle
        launch(two_b1, IV);
        wait_done(1'b0, res, cnt);
        chk("two_b1_model", res, ref_compress(IV, two_b1));
        launch(two_b2, res);
        wait_done(1'b0, res2, cnt);
        chk("two_latency", 256'(cnt), 256'd65);
        chk("two_hash", res2, TWO_H);
        @(negedge clk);

        // start pulses and input scrambling while busy must not disturb the run
        launch(abc_blk, IV);
        pulses = 0;
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                pulses++;
                if (pulses == 1) res = bus.hash_out;
            end
            if (c >= 10 && c <= 40) begin
                bus.start = 1'($urandom_range(0, 1));
                for (int j = 0; j < 16; j++) bus.block_in[32*j +: 32] = $urandom;
                for (int j = 0; j < 8; j++) bus.hash_in[32*j +: 32] = $urandom;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("scramble_pulses", 256'(pulses), 256'd1);
        chk("scramble_hash", res, ABC_H);

        // Reset in the middle of a block
        launch(abc_blk, IV);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_hash", bus.hash_out, 256'd0);
        chk("midrst_busy", {255'd0, bus.busy}, 256'd0);
        chk("midrst_ksel", {250'd0, k_select}, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        chk("midrst_no_done", 256'(pulses), 256'd0);
        launch(abc_blk, IV);
        wait_done(1'b0, res, cnt);
        chk("rerun_latency", 256'(cnt), 256'd65);
        chk("rerun_hash", res, ABC_H);
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
